// File: rtl/store_buffer_pkg.sv
// Shared types and width codes for the posted-write store buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package store_buffer_pkg;

  // Default widths of a buffered entry; the store_buffer parameters default to these.
  localparam int SB_AW = 9;
  localparam int SB_DW = 32;

  // Store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Load width codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;

  // One buffered store: unshifted data, byte address and width code kept verbatim
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
    logic [2:0]       funct3;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_sb_fifo.sv
// Circular store queue; every slot and its valid bit is exposed for the load hazard compare.
// Latency: a pushed entry is at the head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  sb_entry_t                push_entry,
  input  logic                     pop,
  output sb_entry_t                head,
  output sb_entry_t [DEPTH-1:0]    entries,
  output logic [DEPTH-1:0]         valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp];
  assign entries = mem;

  // Pointers, occupancy and per-slot valid bits; pointers wrap naturally (DEPTH is a power of two)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (do_push) begin
        wp        <= wp + 1'b1;
        valid[wp] <= 1'b1;
      end
      if (do_pop) begin
        rp        <= rp + 1'b1;
        valid[rp] <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Slot payload needs no reset: valid bits and count gate every use of it
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp] <= push_entry;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of data memory: queues committed stores, drains one per free port cycle.
// Latency: a store reaches the memory port no earlier than the cycle after it is accepted.
// Backpressure: st_ready low when full or a load is presented; ld_stall while a buffered store hits the load word.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DM_ADDRESS = SB_AW,
  parameter int DATA_W     = SB_DW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [DM_ADDRESS-1:0]   st_addr,
  input  logic [DATA_W-1:0]       st_data,
  input  logic [2:0]              st_funct3,
  input  logic                    ld_req,
  input  logic [DM_ADDRESS-1:0]   ld_addr,
  input  logic [2:0]              ld_funct3,
  output logic                    ld_stall,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DM_ADDRESS-1:0]   mem_addr,
  output logic [DATA_W-1:0]       mem_wd,
  output logic [2:0]              mem_funct3,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  sb_entry_t             push_entry;
  sb_entry_t             head;
  sb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  word_hit;
  logic                  hazard;
  logic                  load_go;

  // The pipeline never presents a store and a load together, so refusing stores during a load is free
  assign st_ready   = !full && !ld_req;
  assign push       = st_valid && st_ready;
  assign push_entry = '{addr: st_addr, data: st_data, funct3: st_funct3};

  sb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .entries    (entries),
    .valid      (valid),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  // Word-granular match of the load against every live entry; no byte overlap, no forwarding
  always_comb begin
    word_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].addr[DM_ADDRESS-1:2] == ld_addr[DM_ADDRESS-1:2])) begin
        word_hit = 1'b1;
      end
    end
  end

  assign hazard   = ld_req && word_hit;
  assign ld_stall = hazard;
  assign load_go  = ld_req && !hazard;
  // A stalled load keeps draining so the matching store leaves as soon as possible
  assign pop      = !load_go && !empty;

  // Port arbitration: clean load first, then head-of-queue drain, otherwise idle with all outputs low
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    mem_funct3 = 3'b000;
    if (load_go) begin
      mem_read   = 1'b1;
      mem_addr   = ld_addr;
      mem_funct3 = ld_funct3;
    end else if (!empty) begin
      mem_write  = 1'b1;
      mem_addr   = head.addr;
      mem_wd     = head.data;
      mem_funct3 = head.funct3;
    end
  end

endmodule
